// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    localparam int unsigned BAUD_W        = 16;
    localparam int unsigned BIT_W         = 4;
    localparam int unsigned MAX_DATA_BITS = 9;

    // Zero-extension of narrower words leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_e                  mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head read and registered occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr, do_rd;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Push is judged on the pre-pop count, so a full FIFO rejects even with a same-cycle pop.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: configurable width, parity and stop bits,
// back-to-back frames with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2604,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          trmt,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_rdy,
    output logic                          TX,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          tx_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

    tx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  ovf_q;

    logic                  pop;
    logic                  boundary;
    logic [DATA_BITS-1:0]  fifo_head;
    logic                  fifo_full, fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (trmt),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign boundary = (baud_q == BAUD_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    par_d   = parity_bit(MAX_DATA_BITS'(fifo_head), PAR_MODE);
                end
            end
            START: begin
                if (boundary) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (boundary) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PAR_MODE != PAR_NONE) ? PAR : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (boundary) begin
                    state_d = STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (boundary) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            state_d = START;
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            par_d   = parity_bit(MAX_DATA_BITS'(fifo_head), PAR_MODE);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin value is registered from the next state so the line never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= trmt && fifo_full;
        end
    end

    assign TX      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign tx_ovf  = ovf_q;
    assign tx_rdy  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: three configurations against a frame-level line model.
module tb_uart_tx_fifo;

    localparam int CLKD  = 16;
    localparam int DEPTH = 4;
    localparam int NDUT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       tx_line [NDUT];
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];
    logic       ovf_w   [NDUT];
    logic       rdy_w   [NDUT];
    logic [2:0] cnt_w   [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 7E2, 2: 8O1
    uart_tx_fifo #(.CLK_DIV(CLKD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut_8n1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .tx_rdy(rdy_w[0]),
        .TX(tx_line[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_ovf(ovf_w[0]),
        .fifo_cnt(cnt_w[0]));

    uart_tx_fifo #(.CLK_DIV(CLKD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .FIFO_DEPTH(DEPTH)) dut_7e2 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data[6:0]), .tx_rdy(rdy_w[1]),
        .TX(tx_line[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_ovf(ovf_w[1]),
        .fifo_cnt(cnt_w[1]));

    uart_tx_fifo #(.CLK_DIV(CLKD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut_8o1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .tx_rdy(rdy_w[2]),
        .TX(tx_line[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_ovf(ovf_w[2]),
        .fifo_cnt(cnt_w[2]));

    function automatic int db(input int i);
        return (i == 1) ? 7 : 8;
    endfunction

    function automatic int par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int sb(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return CLKD * (1 + db(i) + ((par(i) != 0) ? 1 : 0) + sb(i));
    endfunction

    // Value of line bit b of a frame carrying d.
    function automatic logic exp_bit(input int i, input logic [8:0] d, input int b);
        int ones;
        ones = $countones(d);
        if (b == 0) return 1'b0;
        if (b <= db(i)) return d[b-1];
        if (par(i) != 0 && b == db(i) + 1)
            return (par(i) == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending-word array per DUT plus remaining cycles of the frame on the line.
    logic [8:0] m_mem  [NDUT][DEPTH];
    logic [8:0] m_cur  [NDUT];
    int         m_cnt  [NDUT];
    int         m_head [NDUT];
    int         m_left [NDUT];
    logic       m_done [NDUT];
    logic       m_ovf  [NDUT];
    int         cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i]  = 0;
            m_head[i] = 0;
            m_left[i] = 0;
            m_done[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_cur[i]  = '0;
        end
    endtask

    task automatic model_step();
        int pre;
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            pre       = m_cnt[i];
            m_ovf[i]  = trmt && (pre == DEPTH);
            m_done[i] = 1'b0;
            if (m_left[i] > 0) begin
                m_left[i]--;
                m_done[i] = (m_left[i] == 0);
            end
            if (m_left[i] == 0 && pre > 0) begin
                m_cur[i]  = m_mem[i][m_head[i]];
                m_head[i] = (m_head[i] + 1) % DEPTH;
                m_cnt[i]--;
                m_left[i] = frame_len(i);
            end
            if (trmt && pre < DEPTH) begin
                m_mem[i][(m_head[i] + m_cnt[i]) % DEPTH] =
                    (db(i) == 7) ? {2'b00, tx_data[6:0]} : {1'b0, tx_data};
                m_cnt[i]++;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic exp_tx(input int i);
        if (m_left[i] == 0) return 1'b1;
        return exp_bit(i, m_cur[i], (frame_len(i) - m_left[i]) / CLKD);
    endfunction

    bit chk_en  = 1'b0;
    bit gap_en  = 1'b0;
    bit peak_en = 1'b0;
    int last_done = -1;
    int done_n  = 0;
    int ovf_n   = 0;
    int peak    = 0;

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("tx%0d", i),   32'(tx_line[i]), 32'(exp_tx(i)));
                check($sformatf("busy%0d", i), 32'(busy_w[i]),  32'(m_left[i] > 0));
                check($sformatf("done%0d", i), 32'(done_w[i]),  32'(m_done[i]));
                check($sformatf("ovf%0d", i),  32'(ovf_w[i]),   32'(m_ovf[i]));
                check($sformatf("cnt%0d", i),  32'(cnt_w[i]),   32'(m_cnt[i]));
                check($sformatf("rdy%0d", i),  32'(rdy_w[i]),   32'(m_cnt[i] < DEPTH));
            end
            if (ovf_w[0]) ovf_n++;
            if (peak_en && int'(cnt_w[0]) > peak) peak = int'(cnt_w[0]);
            if (gap_en && done_w[0]) begin
                done_n++;
                if (last_done >= 0) check("done_gap", 32'(cyc - last_done), 32'(frame_len(0)));
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_w[0] || busy_w[1] || busy_w[2] ||
                cnt_w[0] != 0 || cnt_w[1] != 0 || cnt_w[2] != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Push one word, then sample DUT idx's line at negedge number at_n after the push edge.
    task automatic probe(input logic [7:0] d, input int idx, input int at_n,
                         input logic exp_v, input string tag);
        trmt    = 1'b1;
        tx_data = d;
        @(negedge clk);
        trmt = 1'b0;
        repeat (at_n - 1) @(negedge clk);
        check(tag, 32'(tx_line[idx]), 32'(exp_v));
        wait_idle(400);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_tx",   32'(tx_line[i]), 32'd1);
            check("rst_busy", 32'(busy_w[i]),  32'd0);
            check("rst_done", 32'(done_w[i]),  32'd0);
            check("rst_ovf",  32'(ovf_w[i]),   32'd0);
            check("rst_rdy",  32'(rdy_w[i]),   32'd1);
            check("rst_cnt",  32'(cnt_w[i]),   32'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single 8'hA5: start bit one cycle after the push edge, done after a full frame.
        trmt    = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        trmt = 1'b0;
        n    = 1;
        check("a5_line_before", 32'(tx_line[0]), 32'd1);
        @(negedge clk);
        n++;
        check("a5_start_bit", 32'(tx_line[0]), 32'd0);
        while (!done_w[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("a5_done_cycle", 32'(n), 32'(frame_len(0) + 2));
        wait_idle(400);

        // Four words in consecutive cycles.
        gap_en    = 1'b1;
        peak_en   = 1'b1;
        last_done = -1;
        done_n    = 0;
        peak      = 0;
        for (int k = 1; k <= 4; k++) begin
            trmt    = 1'b1;
            tx_data = 8'(k);
            @(negedge clk);
        end
        trmt = 1'b0;
        wait_idle(2000);
        check("burst4_peak", 32'(peak), 32'd3);
        check("burst4_done_count", 32'(done_n), 32'd4);
        gap_en  = 1'b0;
        peak_en = 1'b0;

        // Six words back-to-back: the sixth overflows.
        ovf_n = 0;
        for (int k = 0; k < 6; k++) begin
            trmt    = 1'b1;
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        trmt = 1'b0;
        wait_idle(2000);
        check("burst6_ovf_pulses", 32'(ovf_n), 32'd1);

        // Parity and stop-bit probes at bit centres.
        probe(8'h55, 1, 2 + 8 * CLKD + 8,  1'b0, "7e2_parity_55");
        probe(8'h55, 1, 2 + 10 * CLKD + 8, 1'b1, "7e2_second_stop");
        probe(8'h00, 2, 2 + 9 * CLKD + 8,  1'b1, "8o1_parity_00");
        probe(8'hFF, 2, 2 + 9 * CLKD + 8,  1'b1, "8o1_parity_ff");

        // Reset in the middle of the second data bit with two words queued.
        for (int k = 0; k < 3; k++) begin
            trmt    = 1'b1;
            tx_data = 8'h0F + 8'(k);
            @(negedge clk);
        end
        trmt = 1'b0;
        repeat (2 + CLKD * 2 + 8 - 3) @(negedge clk);
        check("pre_reset_cnt", 32'(cnt_w[0]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("mid_rst_tx",   32'(tx_line[i]), 32'd1);
            check("mid_rst_cnt",  32'(cnt_w[i]),   32'd0);
            check("mid_rst_busy", 32'(busy_w[i]),  32'd0);
            check("mid_rst_done", 32'(done_w[i]),  32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("post_rst_idle", 32'(busy_w[0]), 32'd0);

        // Random traffic.
        repeat (3000) begin
            trmt    = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        trmt = 1'b0;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
